// File: rtl/raycast_frame_scheduler.sv
// raycast_frame_scheduler
// Frame-level sequencer for the per-column draw-slice engine. On a frame request it snapshots
// the player position and view angle, starts a screen clear, then walks the slice engine
// across every column with a start/done handshake. A per-column watchdog forces the walk
// forward if the slice engine stalls.
//
// Ports:
//   clock, resetn               clock (rising edge), asynchronous active-low reset
//   frame_req                   level-sampled request for one frame
//   playerX_in/playerY_in       signed player position (13 bits)
//   angleX_in/angleY_in         view angle, integer (signed) and fractional parts (10 bits)
//   clear_done, slice_done      completion strobes from the clear and slice engines
//   clear_start, slice_start    one-cycle start pulses
//   column                      current column index
//   playerX/playerY/angleX/angleY  per-frame snapshot of the inputs
//   busy                        high from frame acceptance through DONE
//   frame_done                  one-cycle pulse when the last column completes
//   timeout_err                 sticky: a column watchdog expired in this frame
module raycast_frame_scheduler #(
  parameter int unsigned NUM_COLS = 160,
  parameter int unsigned COL_W    = 8,
  parameter int unsigned TIMEOUT  = 4095,
  parameter int unsigned TO_W     = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_req,
  input  logic [12:0]      playerX_in,
  input  logic [12:0]      playerY_in,
  input  logic [9:0]       angleX_in,
  input  logic [9:0]       angleY_in,
  input  logic             clear_done,
  input  logic             slice_done,
  output logic             clear_start,
  output logic             slice_start,
  output logic [COL_W-1:0] column,
  output logic [12:0]      playerX,
  output logic [12:0]      playerY,
  output logic [9:0]       angleX,
  output logic [9:0]       angleY,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(NUM_COLS - 1);
  localparam logic [TO_W-1:0]  WdLimit = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StClear, StWaitClear, StIssue, StWaitSlice, StNext, StDone
  } state_e;

  state_e           r_state, w_state;
  logic             r_clear_start, w_clear_start;
  logic             r_slice_start, w_slice_start;
  logic [COL_W-1:0] r_column, w_column;
  logic [12:0]      r_px, w_px, r_py, w_py;
  logic [9:0]       r_ax, w_ax, r_ay, w_ay;
  logic             r_busy, w_busy;
  logic             r_frame_done, w_frame_done;
  logic             r_timeout_err, w_timeout_err;
  logic             r_pending, w_pending;
  logic [TO_W-1:0]  r_wd, w_wd;
  logic [TO_W-1:0]  w_wd_inc;
  logic             w_start;

  assign w_wd_inc = r_wd + TO_W'(1);

  always_comb begin
    w_state       = r_state;
    w_clear_start = 1'b0;
    w_slice_start = 1'b0;
    w_frame_done  = 1'b0;
    w_column      = r_column;
    w_px          = r_px;
    w_py          = r_py;
    w_ax          = r_ax;
    w_ay          = r_ay;
    w_busy        = r_busy;
    w_timeout_err = r_timeout_err;
    // Requests arriving during a frame coalesce into a single pending frame.
    w_pending     = r_pending | (r_busy & frame_req);
    w_wd          = r_wd;
    w_start       = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (frame_req) w_start = 1'b1;
      end
      StClear: w_state = StWaitClear;
      StWaitClear: begin
        if (clear_done) begin
          w_state       = StIssue;
          w_slice_start = 1'b1;
        end
      end
      StIssue: begin
        w_wd    = '0;
        w_state = StWaitSlice;
      end
      StWaitSlice: begin
        w_wd = w_wd_inc;
        // slice_done has priority over a watchdog expiry in the same cycle.
        if (slice_done) begin
          w_state = StNext;
        end else if (w_wd_inc == WdLimit) begin
          w_timeout_err = 1'b1;
          w_state       = StNext;
        end
      end
      StNext: begin
        if (r_column == LastCol) begin
          w_state      = StDone;
          w_frame_done = 1'b1;
        end else begin
          w_column      = r_column + COL_W'(1);
          w_state       = StIssue;
          w_slice_start = 1'b1;
        end
      end
      StDone: begin
        // A request in the DONE cycle itself counts as pending.
        if (r_pending || frame_req) begin
          w_start = 1'b1;
        end else begin
          w_state = StIdle;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = StIdle;
        w_busy  = 1'b0;
      end
    endcase

    // Frame acceptance, shared by IDLE and the back-to-back path out of DONE.
    if (w_start) begin
      w_state       = StClear;
      w_clear_start = 1'b1;
      w_busy        = 1'b1;
      w_pending     = 1'b0;
      w_timeout_err = 1'b0;
      w_column      = '0;
      w_px          = playerX_in;
      w_py          = playerY_in;
      w_ax          = angleX_in;
      w_ay          = angleY_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= StIdle;
      r_clear_start <= 1'b0;
      r_slice_start <= 1'b0;
      r_column      <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_ax          <= '0;
      r_ay          <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pending     <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_state       <= w_state;
      r_clear_start <= w_clear_start;
      r_slice_start <= w_slice_start;
      r_column      <= w_column;
      r_px          <= w_px;
      r_py          <= w_py;
      r_ax          <= w_ax;
      r_ay          <= w_ay;
      r_busy        <= w_busy;
      r_frame_done  <= w_frame_done;
      r_timeout_err <= w_timeout_err;
      r_pending     <= w_pending;
      r_wd          <= w_wd;
    end
  end

  assign clear_start = r_clear_start;
  assign slice_start = r_slice_start;
  assign column      = r_column;
  assign playerX     = r_px;
  assign playerY     = r_py;
  assign angleX      = r_ax;
  assign angleY      = r_ay;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_raycast_frame_scheduler.sv
// tb_raycast_frame_scheduler
// Directed bench for raycast_frame_scheduler with NUM_COLS=4, TIMEOUT=8. A negedge responder
// answers clear_start after 2 cycles and slice_start after 3 cycles (or a per-column override)
// and logs every pulse with its cycle number for latency and sequence checks.
module tb_raycast_frame_scheduler;

  localparam int unsigned NC = 4;
  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        frame_req;
  logic [12:0] playerX_in, playerY_in;
  logic [9:0]  angleX_in, angleY_in;
  logic        clear_done, slice_done;
  logic        clear_start, slice_start;
  logic [1:0]  column;
  logic [12:0] playerX, playerY;
  logic [9:0]  angleX, angleY;
  logic        busy, frame_done, timeout_err;

  raycast_frame_scheduler #(
    .NUM_COLS(NC), .COL_W(2), .TIMEOUT(TO), .TO_W(4)
  ) dut (
    .clock(clock), .resetn(resetn), .frame_req(frame_req),
    .playerX_in(playerX_in), .playerY_in(playerY_in),
    .angleX_in(angleX_in), .angleY_in(angleY_in),
    .clear_done(clear_done), .slice_done(slice_done),
    .clear_start(clear_start), .slice_start(slice_start), .column(column),
    .playerX(playerX), .playerY(playerY), .angleX(angleX), .angleY(angleY),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int clr_cnt = 0, clr_cyc = 0, fd_cnt = 0, fd_cyc = 0, ss_cnt = 0;
  int ss_col[64];
  int ss_cyc[64];
  int cd_t = 0, sd_t = 0;
  int special_col = -1;
  int special_dly = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Handshake responder and pulse logger.
  always @(negedge clock) begin
    if (!resetn) begin
      cd_t       <= 0;
      sd_t       <= 0;
      clear_done <= 1'b0;
      slice_done <= 1'b0;
    end else begin
      clear_done <= (cd_t == 1);
      cd_t       <= clear_start ? 2 : ((cd_t > 0) ? cd_t - 1 : 0);
      slice_done <= (sd_t == 1);
      if (slice_start) sd_t <= (int'(column) == special_col) ? special_dly : 3;
      else             sd_t <= (sd_t > 0) ? sd_t - 1 : 0;
      if (clear_start) begin
        clr_cnt <= clr_cnt + 1;
        clr_cyc <= cyc;
      end
      if (slice_start && ss_cnt < 64) begin
        ss_col[ss_cnt] <= int'(column);
        ss_cyc[ss_cnt] <= cyc;
        ss_cnt         <= ss_cnt + 1;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge clock);
    frame_req = 1'b1;
    @(posedge clock);
    #1;
    frame_req = 1'b0;
  endtask

  // Returns one cycle after the DONE cycle of frame number 'target'.
  task automatic wait_fd(input int target, input bit chg);
    int n = 0;
    while (fd_cnt < target && n < 300) begin
      @(posedge clock);
      #1;
      n++;
      if (chg && busy && column == 2'd1) playerX_in = 13'd500;
    end
    check("frame_done_seen", 32'(fd_cnt >= target), 1);
  endtask

  task automatic wait_ss(input int target);
    int n = 0;
    while (ss_cnt < target && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("slice_start_seen", 32'(ss_cnt >= target), 1);
  endtask

  task automatic pulse_req();
    @(negedge clock);
    frame_req = 1'b1;
    @(negedge clock);
    frame_req = 1'b0;
  endtask

  int b_fd, b_clr, b_ss;

  initial begin
    resetn     = 1'b0;
    frame_req  = 1'b0;
    playerX_in = '0;
    playerY_in = '0;
    angleX_in  = '0;
    angleY_in  = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_column", column, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_cstart", clear_start, 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_busy", busy, 0);

    // Nominal frame plus snapshot hold.
    playerX_in = 13'd100;
    playerY_in = 13'h1FF9;  // -7
    angleX_in  = 10'h3D3;   // -45
    angleY_in  = 10'd300;
    b_fd = fd_cnt; b_clr = clr_cnt; b_ss = ss_cnt;
    start_frame();
    check("acc_busy", busy, 1);
    check("acc_cstart", clear_start, 1);
    check("acc_px", playerX, 100);
    check("acc_ax", angleX, 32'h3D3);
    wait_fd(b_fd + 1, 1'b1);
    check("nom_busy_fall", busy, 0);
    check("nom_fdone_pulse", frame_done, 0);
    check("nom_terr", timeout_err, 0);
    check("nom_clr_cnt", 32'(clr_cnt - b_clr), 1);
    check("nom_ss_cnt", 32'(ss_cnt - b_ss), 4);
    for (int i = 0; i < 4; i++) check("nom_col", 32'(ss_col[b_ss + i]), 32'(i));
    for (int i = 0; i < 3; i++) check("nom_col_period", 32'(ss_cyc[b_ss + i + 1] - ss_cyc[b_ss + i]), 5);
    check("nom_clear_to_issue", 32'(ss_cyc[b_ss] - clr_cyc), 3);
    check("nom_last_to_done", 32'(fd_cyc - ss_cyc[b_ss + 3]), 5);
    check("snap_px", playerX, 100);
    check("snap_py", playerY, 32'h1FF9);
    check("snap_ax", angleX, 32'h3D3);
    check("snap_ay", angleY, 300);
    repeat (3) @(posedge clock);
    #1;
    check("snap_px_idle", playerX, 100);

    // Watchdog on column 2.
    special_col = 2; special_dly = 0;
    b_fd = fd_cnt; b_ss = ss_cnt;
    start_frame();
    check("relatch_px", playerX, 500);
    wait_fd(b_fd + 1, 1'b0);
    check("wd_ss_cnt", 32'(ss_cnt - b_ss), 4);
    check("wd_col3", 32'(ss_col[b_ss + 3]), 3);
    check("wd_period_c1", 32'(ss_cyc[b_ss + 2] - ss_cyc[b_ss + 1]), 5);
    check("wd_period_c2", 32'(ss_cyc[b_ss + 3] - ss_cyc[b_ss + 2]), 10);
    check("wd_terr", timeout_err, 1);
    check("wd_busy", busy, 0);

    // Done/expiry tie on column 1: done wins.
    special_col = 1; special_dly = 8;
    b_fd = fd_cnt; b_ss = ss_cnt;
    start_frame();
    check("tie_terr_cleared", timeout_err, 0);
    wait_fd(b_fd + 1, 1'b0);
    check("tie_period", 32'(ss_cyc[b_ss + 2] - ss_cyc[b_ss + 1]), 10);
    check("tie_terr", timeout_err, 0);

    // One cycle past the limit: expiry.
    special_dly = 9;
    b_fd = fd_cnt; b_ss = ss_cnt;
    start_frame();
    wait_fd(b_fd + 1, 1'b0);
    check("late_period", 32'(ss_cyc[b_ss + 2] - ss_cyc[b_ss + 1]), 10);
    check("late_terr", timeout_err, 1);

    // Back-to-back: two requests during frame 1 coalesce to one extra frame.
    special_col = -1;
    b_fd = fd_cnt; b_clr = clr_cnt; b_ss = ss_cnt;
    start_frame();
    wait_ss(b_ss + 1);
    pulse_req();
    repeat (3) @(posedge clock);
    pulse_req();
    wait_fd(b_fd + 1, 1'b0);
    check("b2b_cstart", clear_start, 1);
    check("b2b_busy_held", busy, 1);
    check("b2b_terr_cleared", timeout_err, 0);
    wait_fd(b_fd + 2, 1'b0);
    check("b2b_busy_fall", busy, 0);
    repeat (6) @(posedge clock);
    #1;
    check("b2b_fd_cnt", 32'(fd_cnt - b_fd), 2);
    check("b2b_clr_cnt", 32'(clr_cnt - b_clr), 2);
    check("b2b_ss_cnt", 32'(ss_cnt - b_ss), 8);
    check("b2b_idle", busy, 0);

    // Asynchronous reset during WAIT_SLICE of column 1 after column 0 timed out.
    special_col = 0; special_dly = 0;
    b_fd = fd_cnt; b_clr = clr_cnt; b_ss = ss_cnt;
    start_frame();
    wait_ss(b_ss + 2);
    #1;
    check("pre_rst_terr", timeout_err, 1);
    check("pre_rst_col", column, 1);
    resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_col", column, 0);
    check("arst_px", playerX, 0);
    check("arst_ax", angleX, 0);
    check("arst_terr", timeout_err, 0);
    check("arst_sstart", slice_start, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    special_col = -1;
    repeat (10) @(posedge clock);
    #1;
    check("arst_no_fdone", 32'(fd_cnt - b_fd), 0);
    check("arst_no_restart", 32'(clr_cnt - b_clr), 1);
    check("arst_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
